// File: rtl/vga_scanout.sv
// vga_scanout: scans the 320x240x3-bit framebuffer and drives a 640x480@60 VGA
// output with every framebuffer pixel doubled to 2x2 screen pixels.
// Ports: clock/reset (async, active-high); ram_address/ram_read_data form the
// framebuffer read port; vga_r/g/b (4 bit), vga_hs/vga_vs (active-low) and a
// one-clock frame_start pulse.
module vga_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int RD_LAT   = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  output logic [18:0] ram_address,
  input  logic [2:0]  ram_read_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int DW = (CLK_DIV > 2) ? 2 : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  // One framebuffer line covers two screen lines of H_ACTIVE/2 entries.
  localparam logic [16:0]   LINE_STEP = 17'(H_ACTIVE / 2);

  // Read data must land before the pe edge that samples it.
  if (CLK_DIV < 2 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_scanout: CLK_DIV must be 2..4");
  end
  if (RD_LAT < 1 || RD_LAT >= CLK_DIV) begin : g_bad_lat
    $error("vga_scanout: RD_LAT must satisfy 1 <= RD_LAT < CLK_DIV");
  end

  logic [DW-1:0] div;
  logic [9:0]    h, v;
  logic [16:0]   line_base;
  logic          pe;

  logic [9:0]    h_nxt, v_nxt;
  logic [16:0]   lb_nxt;
  logic [18:0]   addr_nxt;
  logic          wrap;
  logic          active, hs_low, vs_low;

  assign pe = (div == DIV_LAST);

  // Counter positions for the next pixel period; the address is registered
  // from these so it is stable for the whole period it belongs to.
  always_comb begin
    h_nxt    = h + 10'd1;
    v_nxt    = v;
    lb_nxt   = line_base;
    addr_nxt = 19'd0;
    wrap     = 1'b0;
    if (h == H_LAST) begin
      h_nxt = 10'd0;
      if (v == V_LAST) begin
        v_nxt  = 10'd0;
        lb_nxt = 17'd0;
        wrap   = 1'b1;
      end else begin
        v_nxt = v + 10'd1;
        // odd -> even step inside the active area starts a new fb line
        if (v[0] && (v < V_ACT_M1))
          lb_nxt = line_base + LINE_STEP;
      end
    end
    if ((h_nxt < H_ACT) && (v_nxt < V_ACT))
      addr_nxt = {2'b00, lb_nxt} + {10'd0, h_nxt[9:1]};
  end

  // Flags of the pixel whose data is sampled at the end of this period.
  always_comb begin
    active = (h < H_ACT) && (v < V_ACT);
    hs_low = (h >= HS_BEG) && (h < HS_END);
    vs_low = (v >= VS_BEG) && (v < VS_END);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div         <= '0;
      h           <= 10'd0;
      v           <= 10'd0;
      line_base   <= 17'd0;
      ram_address <= 19'd0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pe) begin
        div         <= '0;
        h           <= h_nxt;
        v           <= v_nxt;
        line_base   <= lb_nxt;
        ram_address <= addr_nxt;
        vga_r       <= {4{active & ram_read_data[2]}};
        vga_g       <= {4{active & ram_read_data[1]}};
        vga_b       <= {4{active & ram_read_data[0]}};
        vga_hs      <= ~hs_low;
        vga_vs      <= ~vs_low;
        frame_start <= wrap;
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: dut_a uses full 640x480 timing (CLK_DIV=2, RD_LAT=1),
// dut_b uses a shrunken raster (24x12 total, CLK_DIV=4, RD_LAT=3) so whole
// frames fit in a short run.
module tb_vga_scanout;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   mode = 0;   // 0: memory returns 3'b011 everywhere; 1: 3'b111 only at address 5

  logic [18:0] addr_a, addr_b;
  logic [2:0]  rd_a, rd_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  vga_scanout dut_a (
    .clock(clock), .reset(reset_a), .ram_address(addr_a), .ram_read_data(rd_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .frame_start(fs_a)
  );

  vga_scanout #(
    .CLK_DIV(4), .RD_LAT(3),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clock(clock), .reset(reset_b), .ram_address(addr_b), .ram_read_data(rd_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .frame_start(fs_b)
  );

  function automatic logic [2:0] pix(input logic [18:0] a);
    if (mode == 0) return 3'b011;
    return (a == 19'd5) ? 3'b111 : 3'b000;
  endfunction

  // framebuffer models: 1-clock and 3-clock read latency
  logic [2:0] pb0, pb1;
  always @(posedge clock) begin
    rd_a <= pix(addr_a);
    pb0  <= pix(addr_b);
    pb1  <= pb0;
    rd_b <= pb1;
  end

  // clocks since reset release
  int cnt_a, cnt_b;
  always @(posedge clock or posedge reset_a)
    if (reset_a) cnt_a <= 0; else cnt_a <= cnt_a + 1;
  always @(posedge clock or posedge reset_b)
    if (reset_b) cnt_b <= 0; else cnt_b <= cnt_b + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input int n);
    while (cnt_a < n) @(negedge clock);
  endtask

  task automatic run_b(input int n);
    while (cnt_b < n) @(negedge clock);
  endtask

  function automatic int rgb_a();
    return {20'd0, r_a, g_a, b_a};
  endfunction

  function automatic int rgb_b();
    return {20'd0, r_b, g_b, b_b};
  endfunction

  initial begin
    int hs_cnt, vs_cnt, fs_num, fs_t0, fs_t1;
    int q, hh, vv, exp_px;

    // ---- reset state
    repeat (3) @(negedge clock);
    check("rst_addr", addr_a, 0);
    check("rst_rgb", rgb_a(), 0);
    check("rst_hs", hs_a, 1);
    check("rst_vs", vs_a, 1);
    check("rst_fs", fs_a, 0);
    check("rst_b_hs", hs_b, 1);

    // ---- dut_a, full timing, memory returns 011
    reset_a = 1'b0;
    run_a(1);           check("addr_0_0", addr_a, 0);
    run_a(2*5 + 1);     check("addr_5_0", addr_a, 2);
    run_a(2*11 + 1);    check("rgb_active_011", rgb_a(), 'h0FF);
    run_a(2*640 + 1);   check("addr_640_0", addr_a, 0);
    run_a(2*656 + 1);   check("hs_h655", hs_a, 1);
    run_a(2*657 + 1);   check("hs_h656", hs_a, 0);
    run_a(2*701 + 1);   check("rgb_blank_h700", rgb_a(), 0);
    run_a(2*752 + 1);   check("hs_h751", hs_a, 0);
    run_a(2*753 + 1);   check("hs_h752", hs_a, 1);

    hs_cnt = 0;
    for (int p = 800; p < 1600; p++) begin
      run_a(2*p + 1);
      if (hs_a == 1'b0) hs_cnt++;
      if (p == 801) check("addr_1_1", addr_a, 0);
    end
    check("hs_low_per_line", hs_cnt, 96);

    run_a(2*1602 + 1);  check("addr_2_2", addr_a, 321);

    // ---- reset mid-frame at (300,2)
    run_a(2*1900 + 1);  check("rgb_before_reset", rgb_a(), 'h0FF);
    reset_a = 1'b1;
    #1;
    check("midrst_addr", addr_a, 0);
    check("midrst_rgb", rgb_a(), 0);
    check("midrst_hs", hs_a, 1);
    check("midrst_vs", vs_a, 1);
    check("midrst_fs", fs_a, 0);
    @(negedge clock);
    mode = 1;
    reset_a = 1'b0;
    run_a(1);  check("restart_addr_c1", addr_a, 0);
    run_a(3);  check("restart_addr_c3", addr_a, 0);

    // ---- alignment: white only at fb address 5 -> cols 10-11, lines 0-1
    for (int p = 2; p < 1700; p++) begin
      run_a(2*p + 1);
      if (p == 2) check("restart_addr_c5", addr_a, 1);
      q  = p - 1;
      hh = q % 800;
      vv = q / 800;
      exp_px = (hh >= 10 && hh <= 11 && vv < 2) ? 'hFFF : 0;
      check($sformatf("align_a_h%0d_v%0d", hh, vv), rgb_a(), exp_px);
    end

    // ---- dut_b: small raster, CLK_DIV=4, RD_LAT=3
    reset_b = 1'b0;
    hs_cnt = 0; vs_cnt = 0; fs_num = 0; fs_t0 = 0; fs_t1 = 0;
    for (int c = 1; c <= 2400; c++) begin
      run_b(c);
      if (fs_b) begin
        fs_num++;
        if (fs_num == 1) fs_t0 = c;
        if (fs_num == 2) fs_t1 = c;
      end
      if (c <= 1152) begin
        if (!hs_b) hs_cnt++;
        if (!vs_b) vs_cnt++;
      end
      if (c == 7)   check("b_addr_first_pe", addr_b, 0);
      if (c == 9)   check("b_addr_p2", addr_b, 1);
      if (c == 734) check("b_addr_last_active", addr_b, 31);
      if (c == 738) check("b_addr_blank_16_7", addr_b, 0);
      if ((c % 4) == 2 && c >= 6 && c <= 4*289 + 2) begin
        q  = c / 4 - 1;
        hh = q % 24;
        vv = (q / 24) % 12;
        exp_px = (hh >= 10 && hh <= 11 && vv < 2) ? 'hFFF : 0;
        check($sformatf("align_b_h%0d_v%0d", hh, vv), rgb_b(), exp_px);
      end
    end
    check("b_fs_count", fs_num, 2);
    check("b_fs_first", fs_t0, 1152);
    check("b_fs_second", fs_t1, 2304);
    check("b_hs_low_clocks", hs_cnt, 192);
    check("b_vs_low_clocks", vs_cnt, 192);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
